// File: rtl/fetch_ctrl_pkg.sv
// Shared encodings for the fetch-stage sequencer: PC mux selects and FSM states.
package fetch_ctrl_pkg;

    localparam logic [1:0] PCSEL_RESET  = 2'b00;
    localparam logic [1:0] PCSEL_IRQ    = 2'b01;
    localparam logic [1:0] PCSEL_SEQ    = 2'b10;
    localparam logic [1:0] PCSEL_BRANCH = 2'b11;

    typedef enum logic [1:0] {
        S_RESET = 2'b00,
        S_RUN   = 2'b01,
        S_WAIT  = 2'b10,
        S_EXC   = 2'b11
    } fetch_state_e;

endpackage

// File: rtl/fetch_wait_timer.sv
// Saturating instruction-memory wait counter.
// The terminal-count output flags the cycle on which the wait has reached MISS_TIMEOUT.
module fetch_wait_timer #(
    parameter int unsigned MISS_TIMEOUT = 16,
    parameter int unsigned CNT_W        = 8
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_clr,
    input  logic i_inc,
    output logic o_tc
);

    localparam logic [CNT_W-1:0] TC_VAL  = CNT_W'(MISS_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] r_wait_cnt;
    logic [CNT_W-1:0] w_wait_cnt_next;

    always_comb begin
        w_wait_cnt_next = r_wait_cnt;
        if (i_clr) begin
            w_wait_cnt_next = '0;
        end else if (i_inc && (r_wait_cnt != CNT_MAX)) begin
            w_wait_cnt_next = r_wait_cnt + 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_wait_cnt <= '0;
        end else begin
            r_wait_cnt <= w_wait_cnt_next;
        end
    end

    assign o_tc = (r_wait_cnt == TC_VAL);

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: selects the next PC source, holds the PC on stalls,
// arbitrates reset / interrupt / branch / sequential fetch and times out slow fetches.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter int unsigned MISS_TIMEOUT = 16,
    parameter int unsigned CNT_W        = 8
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_imem_ready,
    input  logic       i_hazard_stall,
    input  logic       i_branch_req,
    input  logic       i_irq_req,
    input  logic       i_irq_en,
    output logic [1:0] o_pc_sel,
    output logic       o_stall,
    output logic       o_imem_req,
    output logic       o_fetch_valid,
    output logic       o_branch_ack,
    output logic       o_irq_ack,
    output logic       o_epc_wr,
    output logic       o_bus_err
);

    fetch_state_e r_state;
    fetch_state_e w_state_next;
    logic         r_delay_slot;
    logic         w_delay_slot_next;
    logic         w_cnt_clr;
    logic         w_cnt_inc;
    logic         w_timeout;
    logic         w_irq_take;

    fetch_wait_timer #(
        .MISS_TIMEOUT (MISS_TIMEOUT),
        .CNT_W        (CNT_W)
    ) u_wait_timer (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_clr   (w_cnt_clr),
        .i_inc   (w_cnt_inc),
        .o_tc    (w_timeout)
    );

    // A pending branch always beats the interrupt, and the delay slot must not be split.
    assign w_irq_take = i_irq_req & i_irq_en & ~r_delay_slot & ~i_branch_req;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state      <= S_RESET;
            r_delay_slot <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_delay_slot <= w_delay_slot_next;
        end
    end

    always_comb begin
        w_state_next      = r_state;
        w_delay_slot_next = r_delay_slot;
        w_cnt_clr         = 1'b0;
        w_cnt_inc         = 1'b0;
        unique case (r_state)
            S_RESET: begin
                w_state_next      = S_RUN;
                w_delay_slot_next = 1'b0;
                w_cnt_clr         = 1'b1;
            end
            S_RUN, S_WAIT: begin
                if (!i_imem_ready) begin
                    if ((r_state == S_WAIT) && w_timeout) begin
                        w_state_next = S_EXC;
                        w_cnt_clr    = 1'b1;
                    end else begin
                        w_state_next = S_WAIT;
                        w_cnt_inc    = 1'b1;
                    end
                end else begin
                    w_state_next = S_RUN;
                    w_cnt_clr    = 1'b1;
                    // Only an accepted branch opens a delay slot; irq and sequential close it.
                    if (!i_hazard_stall) begin
                        w_delay_slot_next = i_branch_req;
                    end
                end
            end
            S_EXC: begin
                w_state_next      = S_RUN;
                w_delay_slot_next = 1'b0;
                w_cnt_clr         = 1'b1;
            end
            default: begin
                w_state_next      = S_RESET;
                w_delay_slot_next = 1'b0;
                w_cnt_clr         = 1'b1;
            end
        endcase
    end

    always_comb begin
        o_pc_sel      = PCSEL_SEQ;
        o_stall       = 1'b0;
        o_imem_req    = 1'b0;
        o_fetch_valid = 1'b0;
        o_branch_ack  = 1'b0;
        o_irq_ack     = 1'b0;
        o_epc_wr      = 1'b0;
        o_bus_err     = 1'b0;
        unique case (r_state)
            S_RESET: begin
                o_pc_sel = PCSEL_RESET;
            end
            S_RUN, S_WAIT: begin
                o_imem_req    = 1'b1;
                o_fetch_valid = i_imem_ready;
                o_stall       = i_hazard_stall | ~i_imem_ready;
                if (!i_imem_ready) begin
                    o_bus_err = (r_state == S_WAIT) & w_timeout;
                end else if (!i_hazard_stall) begin
                    if (w_irq_take) begin
                        o_pc_sel      = PCSEL_IRQ;
                        o_irq_ack     = 1'b1;
                        o_epc_wr      = 1'b1;
                        o_fetch_valid = 1'b0;
                    end else if (i_branch_req) begin
                        o_pc_sel     = PCSEL_BRANCH;
                        o_branch_ack = 1'b1;
                    end
                end
            end
            S_EXC: begin
                o_pc_sel = PCSEL_IRQ;
                o_epc_wr = 1'b1;
            end
            default: begin
                o_pc_sel = PCSEL_RESET;
            end
        endcase
    end

    a_one_event: assert property (@(posedge i_clk) disable iff (i_reset)
        $onehot0({o_branch_ack, o_irq_ack, o_bus_err}));

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed and randomized bench for fetch_ctrl against a cycle-level behavioural model.
module tb_fetch_ctrl;

    localparam int unsigned TO      = 16;
    localparam logic [31:0] IRQ_VEC = 32'h100;

    localparam logic [8:0] M_SEL   = 9'h180;
    localparam logic [8:0] M_STALL = 9'h040;
    localparam logic [8:0] M_REQ   = 9'h020;
    localparam logic [8:0] M_FV    = 9'h010;
    localparam logic [8:0] M_BACK  = 9'h008;
    localparam logic [8:0] M_IACK  = 9'h004;
    localparam logic [8:0] M_EPC   = 9'h002;
    localparam logic [8:0] M_BERR  = 9'h001;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic rdy = 1'b1;
    logic hz = 1'b0;
    logic br = 1'b0;
    logic irq = 1'b0;
    logic en = 1'b0;

    logic [1:0] pc_sel;
    logic stall, req, fv, back, iack, epc, berr;

    fetch_ctrl #(
        .MISS_TIMEOUT (TO),
        .CNT_W        (8)
    ) dut (
        .i_clk          (clk),
        .i_reset        (reset),
        .i_imem_ready   (rdy),
        .i_hazard_stall (hz),
        .i_branch_req   (br),
        .i_irq_req      (irq),
        .i_irq_en       (en),
        .o_pc_sel       (pc_sel),
        .o_stall        (stall),
        .o_imem_req     (req),
        .o_fetch_valid  (fv),
        .o_branch_ack   (back),
        .o_irq_ack      (iack),
        .o_epc_wr       (epc),
        .o_bus_err      (berr)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Model: "still in reset phase", "exception cycle due", consecutive missed cycles,
    // delay-slot flag, and the PC the fetch unit would hold.
    bit          m_rst  = 1'b1;
    bit          m_exc  = 1'b0;
    bit          m_ds   = 1'b0;
    int          m_miss = 0;
    logic [31:0] m_pc   = 32'h0;
    bit          m_ack  = 1'b0;
    bit          m_epc  = 1'b0;
    logic [31:0] tgt    = 32'h40;

    bit          lit_on   = 1'b0;
    string       lit_nm   = "";
    logic [8:0]  lit_mask = '0;
    logic [8:0]  lit_val  = '0;
    bit          lpc_on   = 1'b0;
    logic [31:0] lpc_val  = '0;

    always @(negedge clk) begin
        logic [8:0] e;
        logic [8:0] a;
        e = '0;
        a = {pc_sel, stall, req, fv, back, iack, epc, berr};
        if (reset || m_rst) begin
            e = '0;
        end else if (m_exc) begin
            e[8:7] = 2'b01;
            e[1]   = 1'b1;
        end else begin
            e[5] = 1'b1;
            if (!rdy) begin
                e[8:7] = 2'b10;
                e[6]   = 1'b1;
                e[0]   = (m_miss == int'(TO));
            end else begin
                e[4]   = 1'b1;
                e[6]   = hz;
                e[8:7] = 2'b10;
                if (!hz) begin
                    if (irq && en && !m_ds && !br) begin
                        e[8:7] = 2'b01;
                        e[2]   = 1'b1;
                        e[1]   = 1'b1;
                        e[4]   = 1'b0;
                    end else if (br) begin
                        e[8:7] = 2'b11;
                        e[3]   = 1'b1;
                    end
                end
            end
        end

        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL cycle t=%0t outputs got=%b want=%b", $time, a, e);
        end
        if (lit_on) begin
            checks++;
            if ((a & lit_mask) !== lit_val) begin
                failures++;
                $display("FAIL %s t=%0t got=%b want=%b (mask %b)", lit_nm, $time,
                         a & lit_mask, lit_val, lit_mask);
            end
        end
        if (lpc_on) begin
            checks++;
            if (m_pc !== lpc_val) begin
                failures++;
                $display("FAIL model_pc t=%0t got=%h want=%h", $time, m_pc, lpc_val);
            end
        end

        m_ack = e[3];
        m_epc = e[1];
        if (!e[6]) begin
            case (e[8:7])
                2'b00:   m_pc = 32'h0;
                2'b01:   m_pc = IRQ_VEC;
                2'b10:   m_pc = m_pc + 32'd4;
                default: m_pc = tgt;
            endcase
        end
        if (reset) begin
            m_rst = 1'b1; m_exc = 1'b0; m_ds = 1'b0; m_miss = 0;
        end else if (m_rst) begin
            m_rst = 1'b0;
        end else if (m_exc) begin
            m_exc = 1'b0; m_ds = 1'b0;
        end else if (!rdy) begin
            if (e[0]) begin
                m_exc = 1'b1; m_miss = 0;
            end else begin
                m_miss++;
            end
        end else begin
            m_miss = 0;
            if (!hz) m_ds = e[3];
        end
    end

    function automatic logic [8:0] sel(input logic [1:0] s);
        return {s, 7'b0};
    endfunction

    task automatic drive(input bit r, input bit d, input bit h, input bit b, input bit q,
                         input bit e);
        @(posedge clk);
        #1;
        reset = r; rdy = d; hz = h; br = b; irq = q; en = e;
        lit_on = 1'b0; lpc_on = 1'b0;
    endtask

    task automatic want(input string n, input logic [8:0] m, input logic [8:0] v);
        lit_on = 1'b1; lit_nm = n; lit_mask = m; lit_val = v & m;
    endtask

    task automatic want_pc(input logic [31:0] v);
        lpc_on = 1'b1; lpc_val = v;
    endtask

    initial begin
        int burst;
        bit r, d, h, b, q, e;
        burst = 0;

        repeat (3) begin
            drive(1, 1, 0, 0, 0, 0);
            want("reset_hold", M_SEL | M_STALL | M_REQ, 9'h0);
        end
        drive(0, 1, 0, 0, 0, 0);
        want("reset_release", M_SEL | M_STALL | M_FV, 9'h0);
        drive(0, 1, 0, 0, 0, 0);
        want("first_fetch", M_SEL | M_STALL | M_FV, sel(2'b10) | M_FV);
        want_pc(32'h0);
        drive(0, 1, 0, 0, 0, 0);
        want_pc(32'h4);
        drive(0, 1, 0, 0, 0, 0);
        want_pc(32'h8);

        tgt = 32'h40;
        drive(0, 1, 0, 1, 0, 0);
        want("branch_ack", M_SEL | M_BACK | M_IACK, sel(2'b11) | M_BACK);
        want_pc(32'hc);
        drive(0, 1, 0, 0, 1, 1);
        want("irq_in_slot", M_SEL | M_IACK, sel(2'b10));
        want_pc(32'h40);
        drive(0, 1, 0, 0, 1, 1);
        want("irq_take", M_SEL | M_IACK | M_EPC | M_FV, sel(2'b01) | M_IACK | M_EPC);
        want_pc(32'h44);
        drive(0, 1, 0, 0, 0, 1);
        want("after_irq", M_SEL, sel(2'b10));
        want_pc(IRQ_VEC);

        for (int k = 0; k < 5; k++) begin
            drive(0, 0, 0, 0, 0, 1);
            want("short_miss", M_STALL | M_BERR | M_FV, M_STALL);
        end
        drive(0, 1, 0, 0, 0, 1);
        want("miss_ready", M_FV | M_STALL, M_FV);
        drive(0, 1, 0, 0, 0, 1);
        want("miss_back_run", M_SEL | M_STALL, sel(2'b10));

        for (int k = 1; k <= 17; k++) begin
            drive(0, 0, 0, 0, 0, 1);
            want("timeout", M_BERR | M_STALL, (k == 17) ? (M_BERR | M_STALL) : M_STALL);
        end
        drive(0, 1, 0, 0, 0, 1);
        want("exc_cycle", M_SEL | M_STALL | M_EPC | M_REQ | M_BERR, sel(2'b01) | M_EPC);
        drive(0, 1, 0, 0, 0, 1);
        want("exc_exit", M_SEL | M_REQ, sel(2'b10) | M_REQ);

        drive(0, 1, 1, 1, 1, 1);
        want("hazard_hold", M_STALL | M_BACK | M_IACK | M_EPC, M_STALL);
        drive(0, 1, 0, 1, 1, 1);
        want("hazard_release", M_BACK | M_IACK | M_SEL, M_BACK | sel(2'b11));
        drive(0, 1, 0, 0, 1, 1);
        want("irq_deferred", M_IACK, 9'h0);
        drive(0, 1, 0, 0, 1, 1);
        want("irq_after_slot", M_IACK | M_EPC, M_IACK | M_EPC);
        drive(0, 1, 0, 0, 0, 0);

        for (int k = 0; k < 8; k++) drive(0, 0, 0, 0, 0, 0);
        #1;
        reset = 1'b1;
        want("async_reset", M_SEL | M_STALL | M_REQ | M_BERR, 9'h0);
        drive(1, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        for (int k = 1; k <= 17; k++) begin
            drive(0, 0, 0, 0, 0, 0);
            want("fresh_timeout", M_BERR, (k == 17) ? M_BERR : 9'h0);
        end
        drive(0, 1, 0, 0, 0, 0);

        for (int n = 0; n < 4000; n++) begin
            r = ($urandom_range(0, 299) == 0);
            if (burst == 0 && $urandom_range(0, 99) == 0) burst = $urandom_range(14, 20);
            if (burst > 0) begin
                d = 1'b0;
                burst--;
            end else begin
                d = ($urandom_range(0, 3) != 0);
            end
            h = ($urandom_range(0, 4) == 0);
            if (br && !m_ack && !m_epc && !reset) begin
                b = 1'b1;
            end else begin
                b = ($urandom_range(0, 5) == 0);
                if (b) tgt = {$urandom_range(0, 65535), 2'b00};
            end
            q = ($urandom_range(0, 7) == 0) ? ~irq : irq;
            e = ($urandom_range(0, 5) != 0);
            drive(r, d, h, b, q, e);
        end

        @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
